// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store controller: funct3 codes, FSM states, request error check.
// Latency: n/a (package).
// Backpressure: n/a (package).
package lsu_pkg;

    // Load funct3 encodings
    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;
    // Store funct3 encodings
    localparam logic [2:0] SB  = 3'b000;
    localparam logic [2:0] SH  = 3'b001;
    localparam logic [2:0] SW  = 3'b010;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RMW_RD,
        ST_WRITE,
        ST_RESP
    } lsu_state_e;

    // Fields of an accepted request that the access states still need.
    // Upper address bits have already been consumed by the range check.
    typedef struct packed {
        logic [2:0]  funct3;
        logic [1:0]  addr_lo;
        logic [31:0] wdata;
    } lsu_req_t;

    // True when the request must be rejected without touching memory.
    function automatic logic lsu_check_err(input logic       we,
                                           input logic [2:0] funct3,
                                           input logic [1:0] addr_lo,
                                           input logic       out_of_range);
        logic err;
        err = out_of_range;
        if (we) begin
            case (funct3)
                SB:      err = err;
                SH:      err = err | addr_lo[0];
                SW:      err = err | (addr_lo != 2'b00);
                default: err = 1'b1;
            endcase
        end else begin
            case (funct3)
                LB, LBU: err = err;
                LH, LHU: err = err | addr_lo[0];
                LW:      err = err | (addr_lo != 2'b00);
                default: err = 1'b1;
            endcase
        end
        return err;
    endfunction

endpackage

// File: rtl/lsu_mem_ctrl_align.sv
// Load lane extraction with sign/zero extension, and store lane merge into a read word.
// Latency: purely combinational.
// Backpressure: none; no handshake.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] word_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] load_o,
    output logic [31:0] merge_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Pick the addressed byte and halfword out of the memory word.
    always_comb begin
        byte_sel = word_i[7:0];
        case (addr_lo_i)
            2'd0: byte_sel = word_i[7:0];
            2'd1: byte_sel = word_i[15:8];
            2'd2: byte_sel = word_i[23:16];
            2'd3: byte_sel = word_i[31:24];
            default: byte_sel = word_i[7:0];
        endcase
        half_sel = addr_lo_i[1] ? word_i[31:16] : word_i[15:0];
    end

    // Extend the selected lane according to the load type.
    always_comb begin
        load_o = word_i;
        case (funct3_i)
            LB:      load_o = {{24{byte_sel[7]}}, byte_sel};
            LBU:     load_o = {24'd0, byte_sel};
            LH:      load_o = {{16{half_sel[15]}}, half_sel};
            LHU:     load_o = {16'd0, half_sel};
            default: load_o = word_i;
        endcase
    end

    // Overlay the store lane onto the word read back from memory.
    always_comb begin
        merge_o = word_i;
        case (funct3_i)
            SB: begin
                case (addr_lo_i)
                    2'd0: merge_o[7:0]   = wdata_i[7:0];
                    2'd1: merge_o[15:8]  = wdata_i[7:0];
                    2'd2: merge_o[23:16] = wdata_i[7:0];
                    2'd3: merge_o[31:24] = wdata_i[7:0];
                    default: merge_o = word_i;
                endcase
            end
            SH: begin
                if (addr_lo_i[1]) merge_o[31:16] = wdata_i[15:0];
                else              merge_o[15:0]  = wdata_i[15:0];
            end
            default: merge_o = wdata_i;
        endcase
    end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store initiator for a word-addressed async-read data memory; RMW for sub-word stores.
// Latency: response 1 cycle after accept (error), 2 (load/SW), 3 (SB/SH).
// Backpressure: req_ready_o high only in IDLE; requests while busy are ignored, response cannot stall.
module lsu_mem_ctrl
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_we_i,
    input  logic [2:0]        req_funct3_i,
    input  logic [31:0]       req_addr_i,
    input  logic [31:0]       req_wdata_i,
    output logic              rsp_valid_o,
    output logic [31:0]       rsp_rdata_o,
    output logic              rsp_err_o,
    output logic              mem_rd_en_o,
    output logic              mem_wr_en_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [31:0]       mem_d_o,
    input  logic [31:0]       mem_d_i
);

    lsu_state_e        state_q, state_d;
    lsu_req_t          req_q;
    logic [31:0]       rdata_q;
    logic              err_q;
    logic [ADDR_W-1:0] maddr_q;
    logic [31:0]       md_q;

    logic              accept;
    logic              out_of_range;
    logic              acc_err;
    logic [31:0]       load_word;
    logic [31:0]       merge_word;

    assign accept       = req_valid_i && (state_q == ST_IDLE);
    assign out_of_range = |(req_addr_i >> (ADDR_W + 2));
    assign acc_err      = lsu_check_err(req_we_i, req_funct3_i, req_addr_i[1:0], out_of_range);

    lsu_align u_align (
        .funct3_i  (req_q.funct3),
        .addr_lo_i (req_q.addr_lo),
        .word_i    (mem_d_i),
        .wdata_i   (req_q.wdata),
        .load_o    (load_word),
        .merge_o   (merge_word)
    );

    // State register; reset drops the enables at once, aborting any access in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Next-state and enable/handshake decode.
    always_comb begin
        state_d     = state_q;
        req_ready_o = 1'b0;
        mem_rd_en_o = 1'b0;
        mem_wr_en_o = 1'b0;
        rsp_valid_o = 1'b0;
        case (state_q)
            ST_IDLE: begin
                req_ready_o = 1'b1;
                if (req_valid_i) begin
                    if (acc_err)            state_d = ST_RESP;
                    else if (!req_we_i)     state_d = ST_LOAD;
                    else if (req_funct3_i == SW) state_d = ST_WRITE;
                    else                    state_d = ST_RMW_RD;
                end
            end
            ST_LOAD: begin
                mem_rd_en_o = 1'b1;
                state_d     = ST_RESP;
            end
            ST_RMW_RD: begin
                mem_rd_en_o = 1'b1;
                state_d     = ST_WRITE;
            end
            ST_WRITE: begin
                mem_wr_en_o = 1'b1;
                state_d     = ST_RESP;
            end
            ST_RESP: begin
                rsp_valid_o = 1'b1;
                state_d     = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Request latch, load result capture and write-data staging.
    // The memory address only moves for requests that will actually access memory.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            maddr_q <= '0;
            md_q    <= '0;
        end else begin
            if (accept) begin
                req_q.funct3  <= req_funct3_i;
                req_q.addr_lo <= req_addr_i[1:0];
                req_q.wdata   <= req_wdata_i;
                rdata_q       <= '0;
                err_q         <= acc_err;
                if (!acc_err) begin
                    maddr_q <= req_addr_i[ADDR_W+1:2];
                    if (req_we_i && (req_funct3_i == SW)) md_q <= req_wdata_i;
                end
            end
            if (state_q == ST_LOAD)   rdata_q <= load_word;
            if (state_q == ST_RMW_RD) md_q    <= merge_word;
        end
    end

    assign rsp_rdata_o = rdata_q;
    assign rsp_err_o   = err_q;
    assign mem_addr_o  = maddr_q;
    assign mem_d_o     = md_q;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed bench for lsu_mem_ctrl: vector table plus reset-abort and busy-hold sequences.
// Latency: n/a.
// Backpressure: n/a.
module tb_lsu_mem_ctrl;

    localparam int ADDR_W = 6;

    logic              clk;
    logic              rst_n;
    logic              req_valid_i;
    logic              req_ready_o;
    logic              req_we_i;
    logic [2:0]        req_funct3_i;
    logic [31:0]       req_addr_i;
    logic [31:0]       req_wdata_i;
    logic              rsp_valid_o;
    logic [31:0]       rsp_rdata_o;
    logic              rsp_err_o;
    logic              mem_rd_en_o;
    logic              mem_wr_en_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [31:0]       mem_d_o;
    logic [31:0]       mem_d_i;

    int n_chk  = 0;
    int n_fail = 0;

    lsu_mem_ctrl #(.ADDR_W(ADDR_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .req_we_i     (req_we_i),
        .req_funct3_i (req_funct3_i),
        .req_addr_i   (req_addr_i),
        .req_wdata_i  (req_wdata_i),
        .rsp_valid_o  (rsp_valid_o),
        .rsp_rdata_o  (rsp_rdata_o),
        .rsp_err_o    (rsp_err_o),
        .mem_rd_en_o  (mem_rd_en_o),
        .mem_wr_en_o  (mem_wr_en_o),
        .mem_addr_o   (mem_addr_o),
        .mem_d_o      (mem_d_o),
        .mem_d_i      (mem_d_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: async read, write on rising edge; bench preload port shares the write process.
    logic [31:0] mem [64];
    logic        pl_we;
    logic [5:0]  pl_idx;
    logic [31:0] pl_dat;
    assign mem_d_i = mem[mem_addr_o];
    always @(posedge clk) begin
        if (pl_we)            mem[pl_idx] <= pl_dat;
        else if (mem_wr_en_o) mem[mem_addr_o] <= mem_d_o;
    end

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
        int          exp_rd;
        int          exp_wr;
        logic        chk_mem;
        logic [31:0] exp_mem;
    } vec_t;

    vec_t vecs [17];

    function automatic vec_t mk(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [31:0] rdata, input logic err,
                                input int lat, input int rd, input int wr,
                                input logic cm, input logic [31:0] em);
        vec_t v;
        v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.exp_rdata = rdata;
        v.exp_err = err; v.exp_lat = lat; v.exp_rd = rd; v.exp_wr = wr;
        v.chk_mem = cm; v.exp_mem = em;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic preload(input int idx, input logic [31:0] dat);
        @(negedge clk);
        pl_we = 1'b1; pl_idx = idx[5:0]; pl_dat = dat;
        @(posedge clk);
        #1 pl_we = 1'b0;
    endtask

    task automatic run_req(input int k, input vec_t v);
        int          guard;
        int          lat, rdp, wrp;
        logic        got, both;
        logic [31:0] rdata;
        logic        err;
        logic [5:0]  waddr;
        logic [5:0]  widx;
        string       tag;
        tag = $sformatf("vec%0d", k);
        widx = v.addr[7:2];
        guard = 0;
        @(negedge clk);
        while (!req_ready_o && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (!req_ready_o) begin
            chk({tag, "_ready_timeout"}, 32'(req_ready_o), 32'd1);
            return;
        end
        req_valid_i = 1'b1; req_we_i = v.we; req_funct3_i = v.f3;
        req_addr_i = v.addr; req_wdata_i = v.wdata;
        @(posedge clk);
        #1 req_valid_i = 1'b0;
        lat = 0; rdp = 0; wrp = 0; got = 1'b0; both = 1'b0;
        rdata = '0; err = 1'b0; waddr = '0;
        for (int c = 1; c <= 8 && !got; c++) begin
            @(negedge clk);
            if (mem_rd_en_o) rdp++;
            if (mem_wr_en_o) begin wrp++; waddr = mem_addr_o; end
            if (mem_rd_en_o && mem_wr_en_o) both = 1'b1;
            if (rsp_valid_o) begin
                got = 1'b1; lat = c; rdata = rsp_rdata_o; err = rsp_err_o;
            end
        end
        chk({tag, "_latency"}, 32'(lat), 32'(v.exp_lat));
        chk({tag, "_rdata"}, rdata, v.exp_rdata);
        chk({tag, "_err"}, 32'(err), 32'(v.exp_err));
        chk({tag, "_rd_pulses"}, 32'(rdp), 32'(v.exp_rd));
        chk({tag, "_wr_pulses"}, 32'(wrp), 32'(v.exp_wr));
        chk({tag, "_rd_wr_overlap"}, 32'(both), 32'd0);
        if (v.exp_wr != 0) chk({tag, "_wr_addr"}, 32'(waddr), 32'(widx));
        if (v.chk_mem) chk({tag, "_mem_word"}, mem[widx], v.exp_mem);
        @(negedge clk);
        chk({tag, "_rsp_one_cycle"}, 32'(rsp_valid_o), 32'd0);
    endtask

    initial begin
        logic [31:0] rsps [$];
        int          rdp;
        rst_n = 1'b0; req_valid_i = 1'b0; req_we_i = 1'b0; req_funct3_i = '0;
        req_addr_i = '0; req_wdata_i = '0; pl_we = 1'b0; pl_idx = '0; pl_dat = '0;

        // we, f3, addr, wdata, exp rdata, err, lat, rd, wr, chk mem, exp mem
        vecs[0]  = mk(0, 3'b000, 32'h8,   32'h0,        32'hFFFFFFF0, 0, 2, 1, 0, 0, 32'h0);
        vecs[1]  = mk(0, 3'b100, 32'h8,   32'h0,        32'h000000F0, 0, 2, 1, 0, 0, 32'h0);
        vecs[2]  = mk(0, 3'b001, 32'hA,   32'h0,        32'hFFFF8000, 0, 2, 1, 0, 0, 32'h0);
        vecs[3]  = mk(0, 3'b101, 32'hA,   32'h0,        32'h00008000, 0, 2, 1, 0, 0, 32'h0);
        vecs[4]  = mk(1, 3'b010, 32'h4,   32'h12345678, 32'h0,        0, 2, 0, 1, 1, 32'h12345678);
        vecs[5]  = mk(0, 3'b010, 32'h4,   32'h0,        32'h12345678, 0, 2, 1, 0, 0, 32'h0);
        vecs[6]  = mk(1, 3'b000, 32'h5,   32'h000000AB, 32'h0,        0, 3, 1, 1, 1, 32'h1234AB78);
        vecs[7]  = mk(1, 3'b001, 32'h6,   32'h0000BEEF, 32'h0,        0, 3, 1, 1, 1, 32'hBEEFAB78);
        vecs[8]  = mk(0, 3'b000, 32'h7,   32'h0,        32'hFFFFFFBE, 0, 2, 1, 0, 0, 32'h0);
        vecs[9]  = mk(0, 3'b101, 32'h6,   32'h0,        32'h0000BEEF, 0, 2, 1, 0, 0, 32'h0);
        vecs[10] = mk(0, 3'b000, 32'h5,   32'h0,        32'hFFFFFFAB, 0, 2, 1, 0, 0, 32'h0);
        vecs[11] = mk(0, 3'b001, 32'h3,   32'h0,        32'h0,        1, 1, 0, 0, 0, 32'h0);
        vecs[12] = mk(0, 3'b010, 32'h6,   32'h0,        32'h0,        1, 1, 0, 0, 0, 32'h0);
        vecs[13] = mk(1, 3'b011, 32'h0,   32'h55555555, 32'h0,        1, 1, 0, 0, 1, 32'h0);
        vecs[14] = mk(1, 3'b010, 32'h100, 32'h77777777, 32'h0,        1, 1, 0, 0, 1, 32'h0);
        vecs[15] = mk(0, 3'b110, 32'h0,   32'h0,        32'h0,        1, 1, 0, 0, 0, 32'h0);
        vecs[16] = mk(1, 3'b000, 32'h0,   32'hFFFFFF11, 32'h0,        0, 3, 1, 1, 1, 32'h00000011);

        repeat (3) @(negedge clk);
        chk("rst_ready",    32'(req_ready_o), 32'd1);
        chk("rst_rsp_vld",  32'(rsp_valid_o), 32'd0);
        chk("rst_rdata",    rsp_rdata_o,      32'd0);
        chk("rst_err",      32'(rsp_err_o),   32'd0);
        chk("rst_rd_en",    32'(mem_rd_en_o), 32'd0);
        chk("rst_wr_en",    32'(mem_wr_en_o), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr_o),  32'd0);
        chk("rst_mem_d",    mem_d_o,          32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 64; i++) preload(i, 32'h0);
        preload(2, 32'h800000F0);

        for (int k = 0; k < 17; k++) run_req(k, vecs[k]);

        // Reset during WRITE of a SW: store must not land, no response afterwards.
        @(negedge clk);
        chk("abort_ready_before", 32'(req_ready_o), 32'd1);
        req_valid_i = 1'b1; req_we_i = 1'b1; req_funct3_i = 3'b010;
        req_addr_i = 32'h8; req_wdata_i = 32'hDEADBEEF;
        @(posedge clk);
        #1 req_valid_i = 1'b0;
        @(negedge clk);
        chk("abort_wr_en_in_write", 32'(mem_wr_en_o), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("abort_wr_en_drops", 32'(mem_wr_en_o), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        rdp = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (rsp_valid_o) rdp++;
        end
        chk("abort_no_rsp",      32'(rdp), 32'd0);
        chk("abort_word2_kept",  mem[2], 32'h800000F0);
        chk("abort_ready_after", 32'(req_ready_o), 32'd1);

        // Busy hold: LW with a new address every cycle; only IDLE edges accept.
        for (int i = 0; i < 12; i++) preload(i, 32'hA0000000 + 32'(i));
        rdp = 0;
        @(negedge clk);
        for (int n = 0; n < 13; n++) begin
            if (rsp_valid_o) rsps.push_back(rsp_rdata_o);
            if (mem_rd_en_o) rdp++;
            req_valid_i = (n < 9); req_we_i = 1'b0; req_funct3_i = 3'b010;
            req_addr_i = 32'(4 * n); req_wdata_i = '0;
            @(negedge clk);
        end
        req_valid_i = 1'b0;
        chk("busy_rsp_count", 32'(rsps.size()), 32'd3);
        chk("busy_rd_pulses", 32'(rdp), 32'd3);
        if (rsps.size() == 3) begin
            chk("busy_rsp0", rsps[0], 32'hA0000000);
            chk("busy_rsp1", rsps[1], 32'hA0000003);
            chk("busy_rsp2", rsps[2], 32'hA0000006);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
